// File: rtl/menu_if.sv
// Keyboard/datapath-to-sequencer bundle: held-key levels and stage pulse in, level/map/en/state out.
interface menu_if;
  logic       key_up;
  logic       key_down;
  logic       key_enter;
  logic       key_esc;
  logic       stage_clear;
  logic [2:0] level;
  logic [2:0] map;
  logic       en;
  logic [1:0] state;

  modport master (
    output key_up, key_down, key_enter, key_esc, stage_clear,
    input  level, map, en, state
  );

  modport slave (
    input  key_up, key_down, key_enter, key_esc, stage_clear,
    output level, map, en, state
  );
endinterface

// File: rtl/menu_controller.sv
// Game sequencer: menu cursor, arm delay, play enable and stage advance on stage_clear.
module menu_controller #(
  parameter int unsigned NUM_ITEMS      = 5,
  parameter int unsigned CONFIRM_CYCLES = 25_000_000,
  parameter int unsigned CLEAR_CYCLES   = 50_000_000
) (
  input logic   clk,
  input logic   rst,
  menu_if.slave bus
);

  localparam int unsigned CNT_MAX    = (CONFIRM_CYCLES > CLEAR_CYCLES) ? CONFIRM_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [2:0]  LAST_MAP   = 3'(NUM_ITEMS - 1);
  localparam logic [2:0]  LAST_LEVEL = 3'(NUM_ITEMS);
  localparam logic [CNT_W-1:0] CONFIRM_LOAD = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD   = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    ARM   = 2'd1,
    PLAY  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       level_q;
  logic [2:0]       map_q;
  logic             en_q;
  logic [CNT_W-1:0] cnt_q;

  logic prev_up, prev_down, prev_enter, prev_esc;
  logic ev_up, ev_down, ev_enter, ev_esc;

  assign ev_up    = bus.key_up    & ~prev_up;
  assign ev_down  = bus.key_down  & ~prev_down;
  assign ev_enter = bus.key_enter & ~prev_enter;
  assign ev_esc   = bus.key_esc   & ~prev_esc;

  // Previous key levels; reset high so a key held through reset gives no event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_up    <= 1'b1;
      prev_down  <= 1'b1;
      prev_enter <= 1'b1;
      prev_esc   <= 1'b1;
    end else begin
      prev_up    <= bus.key_up;
      prev_down  <= bus.key_down;
      prev_enter <= bus.key_enter;
      prev_esc   <= bus.key_esc;
    end
  end

  // Menu / arm / play / clear sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MENU;
      level_q <= 3'd0;
      map_q   <= 3'd0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MENU: begin
          level_q <= 3'd0;
          en_q    <= 1'b0;
          if (ev_enter) begin
            state_q <= ARM;
            cnt_q   <= CONFIRM_LOAD;
          end else if (ev_up && !ev_down) begin
            map_q <= (map_q == 3'd0) ? LAST_MAP : map_q - 3'd1;
          end else if (ev_down && !ev_up) begin
            map_q <= (map_q == LAST_MAP) ? 3'd0 : map_q + 3'd1;
          end
        end
        ARM: begin
          if (ev_esc) begin
            state_q <= MENU;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= PLAY;
            level_q <= map_q + 3'd1;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PLAY: begin
          if (bus.stage_clear) begin
            state_q <= CLEAR;
            en_q    <= 1'b0;
            cnt_q   <= CLEAR_LOAD;
          end else if (ev_esc) begin
            state_q <= MENU;
            level_q <= 3'd0;
            en_q    <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_q == '0) begin
            level_q <= 3'd0;
            if (level_q < LAST_LEVEL) begin
              state_q <= ARM;
              map_q   <= level_q;
              cnt_q   <= CONFIRM_LOAD;
            end else begin
              state_q <= MENU;
              map_q   <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= MENU;
          level_q <= 3'd0;
          map_q   <= 3'd0;
          en_q    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.level = level_q;
  assign bus.map   = map_q;
  assign bus.en    = en_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed bench for menu_controller (NUM_ITEMS=5, CONFIRM_CYCLES=4, CLEAR_CYCLES=8).
module tb_menu_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  menu_if m ();

  menu_controller #(
    .NUM_ITEMS      (5),
    .CONFIRM_CYCLES (4),
    .CLEAR_CYCLES   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int lv, input int mp, input int e);
    chk({tag, ".state"}, 32'(m.state), 32'(st));
    chk({tag, ".level"}, 32'(m.level), 32'(lv));
    chk({tag, ".map"},   32'(m.map),   32'(mp));
    chk({tag, ".en"},    32'(m.en),    32'(e));
  endtask

  // Advance n rising edges, leaving time 1ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // From PLAY at level L (L < 5): clear the stage and ride through to PLAY at L+1.
  task automatic advance_stage();
    m.stage_clear = 1'b1;
    tick(1);
    m.stage_clear = 1'b0;
    tick(8);
    tick(4);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    m.key_up    = 1'b0;
    m.key_down  = 1'b0;
    m.key_enter = 1'b1;
    m.key_esc   = 1'b0;
    m.stage_clear = 1'b0;

    // Reset with enter held throughout
    tick(3);
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b1;
    tick(3);
    chk("enter_held_no_arm", 32'(m.state), 32'd0);
    m.key_enter = 1'b0;
    tick(1);
    chk("enter_release_menu", 32'(m.state), 32'd0);

    // Cursor wrap up from 0
    m.key_up = 1'b1;
    tick(1);
    m.key_up = 1'b0;
    chk("up_wrap", 32'(m.map), 32'd4);
    tick(1);

    // Cursor wrap down from 4
    m.key_down = 1'b1;
    tick(1);
    m.key_down = 1'b0;
    chk("down_wrap", 32'(m.map), 32'd0);
    tick(1);

    // Held down advances once
    m.key_down = 1'b1;
    tick(10);
    m.key_down = 1'b0;
    chk("down_held", 32'(m.map), 32'd1);
    tick(1);

    // Up and down together: no move
    m.key_up   = 1'b1;
    m.key_down = 1'b1;
    tick(1);
    m.key_up   = 1'b0;
    m.key_down = 1'b0;
    chk("up_down_same", 32'(m.map), 32'd1);
    tick(1);

    // Cursor to 2
    m.key_down = 1'b1;
    tick(1);
    m.key_down = 1'b0;
    tick(1);
    chk("cursor_2", 32'(m.map), 32'd2);

    // Enter with down: ARM next cycle, map stays 2
    m.key_enter = 1'b1;
    m.key_down  = 1'b1;
    tick(1);
    m.key_enter = 1'b0;
    m.key_down  = 1'b0;
    chk_all("arm_entry", 1, 0, 2, 0);
    tick(3);
    chk_all("arm_last", 1, 0, 2, 0);
    tick(1);
    chk_all("play_lv3", 2, 3, 2, 1);

    // Esc in PLAY
    m.key_esc = 1'b1;
    tick(1);
    m.key_esc = 1'b0;
    chk_all("play_esc", 0, 0, 2, 0);
    tick(1);

    // Esc in ARM
    m.key_enter = 1'b1;
    tick(1);
    m.key_enter = 1'b0;
    chk("arm_again", 32'(m.state), 32'd1);
    tick(1);
    m.key_esc = 1'b1;
    tick(1);
    m.key_esc = 1'b0;
    chk_all("arm_esc", 0, 0, 2, 0);
    tick(1);

    // Cursor to 1, play level 2
    m.key_up = 1'b1;
    tick(1);
    m.key_up = 1'b0;
    tick(1);
    m.key_enter = 1'b1;
    tick(1);
    m.key_enter = 1'b0;
    tick(4);
    chk_all("play_lv2", 2, 2, 1, 1);

    // stage_clear with esc: CLEAR wins
    m.stage_clear = 1'b1;
    m.key_esc     = 1'b1;
    tick(1);
    m.stage_clear = 1'b0;
    m.key_esc     = 1'b0;
    chk_all("clear_over_esc", 3, 2, 1, 0);
    m.key_up = 1'b1;
    tick(2);
    m.key_up = 1'b0;
    tick(5);
    chk_all("clear_last", 3, 2, 1, 0);
    tick(1);
    chk_all("clear_to_arm", 1, 0, 2, 0);
    tick(3);
    chk("arm_after_clear", 32'(m.state), 32'd1);
    tick(1);
    chk_all("play_lv3b", 2, 3, 2, 1);

    // Climb to the final stage
    advance_stage();
    chk_all("play_lv4", 2, 4, 3, 1);
    advance_stage();
    chk_all("play_lv5", 2, 5, 4, 1);

    // Final stage clear with key activity during CLEAR
    m.stage_clear = 1'b1;
    tick(1);
    m.stage_clear = 1'b0;
    m.key_enter = 1'b1;
    m.key_down  = 1'b1;
    tick(2);
    m.key_enter = 1'b0;
    m.key_down  = 1'b0;
    m.key_esc   = 1'b1;
    tick(2);
    m.key_esc   = 1'b0;
    tick(3);
    chk_all("final_clear_hold", 3, 5, 4, 0);
    tick(1);
    chk_all("final_to_menu", 0, 0, 0, 0);
    tick(2);
    chk("final_menu_stays", 32'(m.state), 32'd0);

    // Reset mid-CLEAR, checked before the next edge
    m.key_enter = 1'b1;
    tick(1);
    m.key_enter = 1'b0;
    tick(4);
    chk_all("play_lv1", 2, 1, 0, 1);
    m.stage_clear = 1'b1;
    tick(1);
    m.stage_clear = 1'b0;
    tick(2);
    chk("mid_clear", 32'(m.state), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    tick(1);
    rst = 1'b1;
    tick(2);
    chk_all("after_reset", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
